mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port memory between instruction fetch and the datapath's load/store interface, so the core can run on a unified instruction/data memory.
- Sits between the core (PC/fetch side and the dmem master side) and the memory.
- Sequences each transaction with a request/grant/response handshake; at most one transaction outstanding.
- Data has priority; a streak counter stops data traffic from starving fetch.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_STREAK, 4, consecutive data grants allowed while fetch is waiting before fetch is forced to win (min 1)
TIMEOUT, 16, cycles without memory progress before abort (used only with the optional feature; min 2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
if_req  input  1  fetch request; held with if_addr until if_gnt
if_addr  input  AW  fetch address
if_gnt  output  1  one-cycle pulse: fetch request accepted
if_rvalid  output  1  one-cycle pulse: if_rdata valid
if_rdata  output  DW  fetch data
d_req  input  1  data request; held with d_we/d_addr/d_wdata until d_gnt
d_we  input  1  1 = store, 0 = load
d_addr  input  AW  data address
d_wdata  input  DW  store data
d_gnt  output  1  one-cycle pulse: data request accepted
d_rvalid  output  1  one-cycle pulse: load data valid / store done
d_rdata  output  DW  load data
mem_req  output  1  memory request; held until mem_gnt
mem_we  output  1  memory write enable
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_gnt  input  1  memory accepted request
mem_rvalid  input  1  memory response; asserted for reads and writes
mem_rdata  input  DW  memory read data
busy  output  1  arbiter not IDLE
err  output  1  one-cycle pulse: transaction aborted by timeout

Behaviour:
- Reset: state IDLE; streak counter, timeout counter and owner cleared.
  - All outputs 0, including mem_req, mem_we, mem_addr, mem_wdata.
  - Reset mid-transaction drops mem_req immediately; any later mem_rvalid is ignored.
- States:
  - IDLE: no transaction.
  - REQ: mem_req = 1 from registered owner, we, addr and wdata.
  - RSP: waiting for mem_rvalid.
- IDLE arbitration (registered decision):
  - Data wins if d_req and not (if_req and streak == MAX_STREAK); otherwise fetch wins if if_req.
  - Winner receives gnt in the same cycle (combinational from state and req). Request fields latched; next state REQ.
  - Fetch requests are latched as reads (we = 0).
  - Latency: req high in cycle N, mem_req high in cycle N+1.
- Streak counter:
  - +1 on a data grant while if_req = 1; saturates at MAX_STREAK.
  - Cleared on any fetch grant, or on a data grant while if_req = 0.
- REQ: when mem_gnt = 1, go to RSP. mem_req deasserts in the next cycle.
- RSP:
  - When mem_rvalid = 1: owner's rvalid = 1 and rdata = mem_rdata, combinational pass-through in that cycle. Next state IDLE.
  - Non-owner rvalid stays 0; its rdata is don't-care and driven 0.
- Back-to-back throughput: new grant no earlier than the cycle after rvalid. Minimum 3 cycles per transaction with zero-wait memory.
- Simultaneous if_req and d_req in IDLE: resolved strictly by the priority rule above; the loser keeps its request held.
- mem_rvalid outside RSP and mem_gnt outside REQ: ignored.
- busy = (state != IDLE).

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - Timeout counter cleared on entry to REQ and RSP; increments each cycle in either state.
  - On reaching TIMEOUT-1 without mem_gnt (REQ) or mem_rvalid (RSP): abort to IDLE.
  - On abort, err, the owner's rvalid and owner rdata = 0 are asserted for one cycle. mem_req drops.
  - A response arriving in the same cycle as timeout wins: normal completion, no err.
- MEM_TIMEOUT_EN undefined: no counter; waits indefinitely; err tied 0.

Test Plan:
- Single fetch: if_req, if_addr = 0x10; mem_gnt after 2 cycles; mem_rvalid with 0xDEADBEEF -> if_gnt pulse at cycle 0, mem_req cycles 1–3, if_rvalid with if_rdata = 0xDEADBEEF; d_rvalid = 0.
- Store: d_req, d_we = 1, d_addr = 0x40, d_wdata = 0x1234 -> mem_we = 1, mem_addr = 0x40, mem_wdata = 0x1234; d_rvalid pulse on mem_rvalid.
- Contention: if_req and d_req held continuously, MAX_STREAK = 4 -> grant order D, D, D, D, F, D, D, D, D, F.
- Reset mid-RSP: rst asserted while waiting; mem_rvalid pulses after release -> mem_req = 0 immediately, no rvalid to either requester, busy = 0.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT = 16): mem_gnt never asserted -> after 15 cycles in REQ, err and if_rvalid pulse with rdata = 0; IDLE next cycle. Without the macro: mem_req stays high indefinitely.
- Stray responses: mem_rvalid and mem_gnt pulsed while in IDLE -> no rvalid or gnt to either requester; state stays IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store. Data requests win unless fetch has waited MAX_STREAK grants.
// Decision is registered: req in cycle N gives mem_req in N+1. One transaction at a time. MEM_TIMEOUT_EN adds a watchdog abort.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  localparam int SW = $clog2(MAX_STREAK + 1);

  state_t          state, state_nxt;
  logic [SW-1:0]   streak;
  logic            owner_d;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic            data_win, fetch_win;
  logic            done, abort;
  logic            tmo;

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] tcnt;

  assign tmo = (tcnt == TW'(TIMEOUT - 1));

  // Restarts on every state change, so each of REQ and RSP gets its own budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (state_nxt != state) begin
      tcnt <= '0;
    end else if (state != IDLE) begin
      tcnt <= tcnt + TW'(1);
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    data_win  = d_req && !(if_req && (streak == SW'(MAX_STREAK)));
    fetch_win = if_req && !data_win;
    case (state)
      IDLE: begin
        if (data_win) begin
          d_gnt     = 1'b1;
          state_nxt = REQ;
        end else if (fetch_win) begin
          if_gnt    = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_nxt = RSP;
        end else if (tmo) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      RSP: begin
        // A response in the timeout cycle still completes normally.
        if (mem_rvalid) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (tmo) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      streak  <= '0;
      owner_d <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (d_gnt) begin
        owner_d <= 1'b1;
        r_we    <= d_we;
        r_addr  <= d_addr;
        r_wdata <= d_wdata;
        if (!if_req) begin
          streak <= '0;
        end else if (streak != SW'(MAX_STREAK)) begin
          streak <= streak + SW'(1);
        end
      end else if (if_gnt) begin
        owner_d <= 1'b0;
        r_we    <= 1'b0;
        r_addr  <= if_addr;
        r_wdata <= '0;
        streak  <= '0;
      end
    end
  end

  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req & r_we;
  assign mem_addr  = mem_req ? r_addr : '0;
  assign mem_wdata = mem_req ? r_wdata : '0;

  assign if_rvalid = (done | abort) & ~owner_d;
  assign d_rvalid  = (done | abort) & owner_d;
  assign if_rdata  = (done && !owner_d) ? mem_rdata : '0;
  assign d_rdata   = (done && owner_d) ? mem_rdata : '0;

  assign busy = (state != IDLE);
  assign err  = abort;

endmodule
